// File: rtl/obi_ssram_arbiter_pkg.sv
// obi_ssram_arbiter_pkg: shared types and byte-merge helper for the SSRAM arbiter
package riscv_pkg;

    typedef enum logic {IDLE, RMW} arb_state_e;
    typedef enum logic {OWN_FETCH, OWN_LSU} arb_owner_e;

    // pending response: valid flag plus whether the access was a read
    typedef struct packed {
        logic valid;
        logic read;
    } rsp_t;

    localparam logic [3:0] BE_FULL = 4'hF;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/obi_ssram_arbiter_if.sv
// obi_ssram_arbiter_if: fetch and LSU OBI ports plus the single-port SRAM bus
interface obi_ssram_arbiter_if #(parameter int MEM_AW = 10);
    logic              f_req, f_we, f_gnt, f_rvalid;
    logic [31:0]       f_addr, f_wdata, f_rdata;
    logic [3:0]        f_be;
    logic              l_req, l_we, l_gnt, l_rvalid;
    logic [31:0]       l_addr, l_wdata, l_rdata;
    logic [3:0]        l_be;
    logic              csb, web;
    logic [MEM_AW-1:0] addr;
    logic [31:0]       din, dout;

    modport slave (
        input  f_req, f_we, f_addr, f_be, f_wdata,
        input  l_req, l_we, l_addr, l_be, l_wdata,
        input  dout,
        output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
        output csb, web, addr, din
    );

    modport master (
        output f_req, f_we, f_addr, f_be, f_wdata,
        output l_req, l_we, l_addr, l_be, l_wdata,
        output dout,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
        input  csb, web, addr, din
    );
endinterface

// File: rtl/obi_ssram_arbiter.sv
// obi_ssram_arbiter: shares one SSRAM port between fetch and LSU, with read-modify-write for partial writes
module obi_ssram_arbiter
    import riscv_pkg::*;
#(
    parameter bit RR_EN  = 1'b1,
    parameter int MEM_AW = 10
) (
    input logic              CLK,
    input logic              RSTn,
    obi_ssram_arbiter_if.slave bus
);

    arb_state_e  state_q, state_d;
    arb_owner_e  owner_q, owner_d, last_q, last_d, sel, mux_own;
    rsp_t        rsp_q, rsp_d;
    logic        grant, partial, rmw, cur_we;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;
    logic        unused_addr;

    // arbitration, owner mux and next-state; outputs are gated by RSTn so reset acts immediately
    always_comb begin
        rmw       = state_q == RMW;
        sel       = (bus.l_req && (!bus.f_req || !RR_EN || last_q == OWN_FETCH)) ? OWN_LSU : OWN_FETCH;
        grant     = RSTn && !rmw && (bus.f_req || bus.l_req);
        mux_own   = rmw ? owner_q : sel;
        cur_we    = mux_own == OWN_LSU ? bus.l_we    : bus.f_we;
        cur_addr  = mux_own == OWN_LSU ? bus.l_addr  : bus.f_addr;
        cur_be    = mux_own == OWN_LSU ? bus.l_be    : bus.f_be;
        cur_wdata = mux_own == OWN_LSU ? bus.l_wdata : bus.f_wdata;
        partial   = cur_we && cur_be != BE_FULL;
        state_d   = (grant && partial) ? RMW : IDLE;
        owner_d   = grant ? sel : owner_q;
        last_d    = grant ? sel : last_q;
        rsp_d     = rsp_t'{grant, !cur_we};
    end

    assign bus.f_gnt    = grant && sel == OWN_FETCH;
    assign bus.l_gnt    = grant && sel == OWN_LSU;
    assign bus.f_rvalid = rsp_q.valid && owner_q == OWN_FETCH;
    assign bus.l_rvalid = rsp_q.valid && owner_q == OWN_LSU;
    assign bus.f_rdata  = (bus.f_rvalid && rsp_q.read) ? bus.dout : 32'h0;
    assign bus.l_rdata  = (bus.l_rvalid && rsp_q.read) ? bus.dout : 32'h0;
    assign bus.csb      = !(grant || rmw);
    assign bus.web      = rmw ? 1'b0 : !(grant && cur_we && !partial);
    assign bus.addr     = RSTn ? cur_addr[MEM_AW+1:2] : '0;
    assign bus.din      = !RSTn ? 32'h0 : rmw ? byte_merge(bus.dout, cur_wdata, cur_be) : cur_wdata;
    assign unused_addr  = ^{cur_addr[31:MEM_AW+2], cur_addr[1:0]};

    // state, owner, last-granted and pending-response registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            owner_q <= OWN_FETCH;
            last_q  <= OWN_LSU;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rsp_q   <= rsp_d;
        end
    end

endmodule

// File: tb/tb_obi_ssram_arbiter.sv
// tb_obi_ssram_arbiter: directed checks of grant, response, RMW and reset behaviour
module tb_obi_ssram_arbiter;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pl = 1'b1;
    logic [9:0]  pl_addr = 10'd4;
    logic [31:0] pl_data = 32'hDEADBEEF;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];

    always #5 clk = ~clk;

    obi_ssram_arbiter_if a ();
    obi_ssram_arbiter_if b ();

    obi_ssram_arbiter #(.RR_EN(1'b1), .MEM_AW(10)) u_rr (.CLK(clk), .RSTn(rst_n), .bus(a));
    obi_ssram_arbiter #(.RR_EN(1'b0), .MEM_AW(10)) u_fp (.CLK(clk), .RSTn(rst_n), .bus(b));

    // SRAM models with a preload path; read data appears the cycle after csb
    always @(posedge clk) begin
        if (pl) mem_a[pl_addr] <= pl_data;
        else if (!a.csb) begin
            if (!a.web) mem_a[a.addr] <= a.din;
            a.dout <= mem_a[a.addr];
        end
    end

    always @(posedge clk) begin
        if (pl) mem_b[pl_addr] <= pl_data;
        else if (!b.csb) begin
            if (!b.web) mem_b[b.addr] <= b.din;
            b.dout <= mem_b[b.addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drv_f(input logic req, input logic we, input logic [31:0] ad, input logic [3:0] be, input logic [31:0] wd);
        a.f_req = req; a.f_we = we; a.f_addr = ad; a.f_be = be; a.f_wdata = wd;
        b.f_req = req; b.f_we = we; b.f_addr = ad; b.f_be = be; b.f_wdata = wd;
    endtask

    task automatic drv_l(input logic req, input logic we, input logic [31:0] ad, input logic [3:0] be, input logic [31:0] wd);
        a.l_req = req; a.l_we = we; a.l_addr = ad; a.l_be = be; a.l_wdata = wd;
        b.l_req = req; b.l_we = we; b.l_addr = ad; b.l_be = be; b.l_wdata = wd;
    endtask

    initial begin
        drv_f(1'b1, 1'b1, 32'h10, 4'hF, 32'h1234_5678);
        drv_l(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        #1;
        chk("rst_f_gnt", a.f_gnt, 0);
        chk("rst_l_gnt", a.l_gnt, 0);
        chk("rst_csb", a.csb, 1);
        chk("rst_web", a.web, 1);
        chk("rst_addr", a.addr, 0);
        chk("rst_din", a.din, 0);
        chk("rst_f_rvalid", a.f_rvalid, 0);
        chk("rst_l_rvalid", a.l_rvalid, 0);
        chk("rst_f_rdata", a.f_rdata, 0);
        @(negedge clk);
        pl_addr = 10'd8; pl_data = 32'h1122_3344;
        @(negedge clk);
        pl = 1'b0;
        rst_n = 1'b1;
        drv_f(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        drv_l(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("rd_f_gnt", a.f_gnt, 1);
        chk("rd_l_gnt", a.l_gnt, 0);
        chk("rd_csb", a.csb, 0);
        chk("rd_web", a.web, 1);
        chk("rd_addr", a.addr, 4);
        @(negedge clk);
        drv_f(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("rd_f_rvalid", a.f_rvalid, 1);
        chk("rd_f_rdata", a.f_rdata, 32'hDEADBEEF);
        chk("rd_l_rvalid", a.l_rvalid, 0);
        chk("rd_l_rdata", a.l_rdata, 0);
        chk("idle_csb", a.csb, 1);
        @(negedge clk);
        drv_l(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        #1;
        chk("lrd_l_gnt", a.l_gnt, 1);
        chk("lrd_addr", a.addr, 8);
        @(negedge clk);
        drv_l(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("lrd_l_rvalid", a.l_rvalid, 1);
        chk("lrd_l_rdata", a.l_rdata, 32'h1122_3344);
        chk("lrd_f_rdata", a.f_rdata, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drv_f(k < 4, 1'b0, 32'h10, 4'hF, 32'h0);
            drv_l(k < 4, 1'b0, 32'h20, 4'hF, 32'h0);
            #1;
            if (k < 4) begin
                chk($sformatf("rr_f_gnt%0d", k), a.f_gnt, (k % 2) == 0);
                chk($sformatf("rr_l_gnt%0d", k), a.l_gnt, (k % 2) == 1);
                chk($sformatf("fp_f_gnt%0d", k), b.f_gnt, 0);
                chk($sformatf("fp_l_gnt%0d", k), b.l_gnt, 1);
            end
            if (k > 0) begin
                chk($sformatf("rr_f_rvalid%0d", k), a.f_rvalid, (k % 2) == 1);
                chk($sformatf("rr_l_rvalid%0d", k), a.l_rvalid, (k % 2) == 0);
                chk($sformatf("rr_f_rdata%0d", k), a.f_rdata, (k % 2) == 1 ? 32'hDEADBEEF : 32'h0);
                chk($sformatf("rr_l_rdata%0d", k), a.l_rdata, (k % 2) == 0 ? 32'h1122_3344 : 32'h0);
                chk($sformatf("fp_l_rdata%0d", k), b.l_rdata, 32'h1122_3344);
            end
        end
        @(negedge clk);
        drv_l(1'b1, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD);
        #1;
        chk("rmw_n_l_gnt", a.l_gnt, 1);
        chk("rmw_n_csb", a.csb, 0);
        chk("rmw_n_web", a.web, 1);
        chk("rmw_n_addr", a.addr, 8);
        @(negedge clk);
        drv_f(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        #1;
        chk("rmw_n1_csb", a.csb, 0);
        chk("rmw_n1_web", a.web, 0);
        chk("rmw_n1_addr", a.addr, 8);
        chk("rmw_n1_din", a.din, 32'h11BB_33DD);
        chk("rmw_n1_f_gnt", a.f_gnt, 0);
        chk("rmw_n1_l_gnt", a.l_gnt, 0);
        chk("rmw_n1_l_rvalid", a.l_rvalid, 1);
        chk("rmw_n1_l_rdata", a.l_rdata, 0);
        @(negedge clk);
        drv_f(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drv_l(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        #1;
        chk("rmw_n2_l_gnt", a.l_gnt, 1);
        chk("rmw_n2_l_rvalid", a.l_rvalid, 0);
        @(negedge clk);
        drv_l(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("rmw_rd_rvalid", a.l_rvalid, 1);
        chk("rmw_rd_rdata", a.l_rdata, 32'h11BB_33DD);
        @(negedge clk);
        drv_l(1'b1, 1'b1, 32'h20, 4'b0001, 32'h0000_00FF);
        #1;
        chk("abrt_l_gnt", a.l_gnt, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abrt_csb", a.csb, 1);
        chk("abrt_web", a.web, 1);
        chk("abrt_din", a.din, 0);
        chk("abrt_l_rvalid", a.l_rvalid, 0);
        drv_l(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drv_l(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        #1;
        chk("abrt_rel_l_rvalid", a.l_rvalid, 0);
        chk("abrt_rel_l_gnt", a.l_gnt, 1);
        @(negedge clk);
        drv_l(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("abrt_mem_rdata", a.l_rdata, 32'h11BB_33DD);
        @(negedge clk);
        #1;
        chk("abrt_no_rvalid", a.l_rvalid, 0);
        @(negedge clk);
        drv_l(1'b1, 1'b1, 32'h0, 4'hF, 32'h55);
        #1;
        chk("raw_w_gnt", a.l_gnt, 1);
        chk("raw_w_web", a.web, 0);
        chk("raw_w_din", a.din, 32'h55);
        chk("raw_w_addr", a.addr, 0);
        @(negedge clk);
        drv_l(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drv_f(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        #1;
        chk("raw_r_gnt", a.f_gnt, 1);
        chk("raw_w_rvalid", a.l_rvalid, 1);
        chk("raw_w_rdata", a.l_rdata, 0);
        @(negedge clk);
        drv_f(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("raw_r_rvalid", a.f_rvalid, 1);
        chk("raw_r_rdata", a.f_rdata, 32'h55);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
